nav_sequencer: RTL and testbench

Parametrised successor to the rover navigation controller. Runs the full closed loop, repeated until arrival or attempt limit:
- locate the rover by ultrasound
- probe-move to learn its orientation
- compute and transmit a move command over IR
- re-locate and check for arrival

All math helpers (orientation, move calculation, arrival check) sit outside this block behind req/done handshakes. Adds ultrasound timeout, attempt limit, abort, and fault reporting.

---
 rtl/nav_pkg.sv | 39 +++
 rtl/nav_if.sv | 45 ++++
 rtl/nav_timer.sv | 23 ++
 rtl/nav_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_nav_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nav_pkg.sv
// Shared definitions for the rover navigation sequencer: state codes, fault
// codes and the field positions inside location and command words.
package nav_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'h0,
    ST_US1     = 4'h1,
    ST_SETTLE1 = 4'h2,
    ST_PROBE   = 4'h3,
    ST_US2     = 4'h4,
    ST_SETTLE2 = 4'h5,
    ST_ORIENT  = 4'h6,
    ST_CALC    = 4'h7,
    ST_MOVE    = 4'h8,
    ST_US3     = 4'h9,
    ST_CHECK   = 4'hA,
    ST_FAULT   = 4'hF
  } nav_state_t;

  typedef enum logic [1:0] {
    FLT_NONE       = 2'd0,
    FLT_US_TIMEOUT = 2'd1,
    FLT_ATTEMPTS   = 2'd2
  } nav_fault_t;

  // location word: [7:0] r, [LOC_W-1:8] theta; command word: [7:0] duration
  localparam int R_LSB     = 0;
  localparam int R_MSB     = 7;
  localparam int THETA_LSB = 8;
  localparam int DUR_LSB   = 0;
  localparam int DUR_MSB   = 7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/nav_if.sv
// Bundle of every sequencer signal except clock/reset; master is the
// sequencer, slave is the surrounding rover/helper logic.
interface nav_if #(
  parameter int LOC_W = 12,
  parameter int CMD_W = 12,
  parameter int AW    = 4
);
  logic             enable;
  logic             abort;
  logic [LOC_W-1:0] rover_location;
  logic             ultrasound_done;
  logic             orient_done;
  logic             calc_done;
  logic [CMD_W-1:0] calc_cmd;
  logic             check_done;
  logic             at_target;
  logic             run_ultrasound;
  logic             orient_req;
  logic             calc_req;
  logic             check_req;
  logic             transmit_ir;
  logic [CMD_W-1:0] move_command;
  logic [LOC_W-1:0] original_location;
  logic [LOC_W-1:0] updated_location;
  logic             reached_target;
  logic [1:0]       fault;
  logic [AW-1:0]    attempt;
  logic [3:0]       state;

  modport master (
    input  enable, abort, rover_location, ultrasound_done, orient_done,
           calc_done, calc_cmd, check_done, at_target,
    output run_ultrasound, orient_req, calc_req, check_req, transmit_ir,
           move_command, original_location, updated_location,
           reached_target, fault, attempt, state
  );

  modport slave (
    output enable, abort, rover_location, ultrasound_done, orient_done,
           calc_done, calc_cmd, check_done, at_target,
    input  run_ultrasound, orient_req, calc_req, check_req, transmit_ir,
           move_command, original_location, updated_location,
           reached_target, fault, attempt, state
  );
endinterface

// File: rtl/nav_timer.sv
// Loadable down-counter that stops at zero; one instance serves the settle,
// move and ultrasound-timeout waits since only one is ever active.
module nav_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);
  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset)                r_count <= '0;
    else if (i_clr)            r_count <= '0;
    else if (i_load)           r_count <= i_load_val;
    else if (r_count != '0)    r_count <= r_count - W'(1);
  end

  assign o_zero = (r_count == '0);
endmodule

// File: rtl/nav_sequencer.sv
// Closed-loop rover navigation: locate, probe, orient, compute, move, check,
// repeated until arrival, attempt limit, ultrasound timeout or abort.
module nav_sequencer
  import nav_pkg::*;
#(
  parameter int                 LOC_W         = 12,
  parameter int                 CMD_W         = 12,
  parameter int unsigned        SETTLE_CYCLES = 27000000,
  parameter int unsigned        UNIT_CYCLES   = 27000000,
  parameter logic [CMD_W-1:0]   PROBE_CMD     = 12'h005,
  parameter int unsigned        US_TIMEOUT    = 54000000,
  parameter int unsigned        MAX_ATTEMPTS  = 8
) (
  input logic  clock,
  input logic  reset,
  nav_if.master bus
);
  // state    | meaning
  // IDLE     | wait for enable        US1/2/3 | ultrasound busy, timeout armed
  // SETTLE1/2| settle then sample     PROBE/MOVE | move timer running
  // ORIENT/CALC/CHECK | await helper  FAULT | hold fault until enable low

  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam longint unsigned MOVE_MAX = 64'(255) * 64'(UNIT_CYCLES);
  localparam int W_MOVE = $clog2(MOVE_MAX + 64'd1);
  localparam int W_SET  = $clog2(64'(SETTLE_CYCLES) + 64'd1);
  localparam int W_TO   = $clog2(64'(US_TIMEOUT) + 64'd1);
  localparam int TW     = max3(W_MOVE, W_SET, W_TO);

  // timer holds "remaining cycles - 1" so a state exits when it reads zero
  localparam logic [TW-1:0] TO_LOAD     = (US_TIMEOUT == 0)    ? '0 : TW'(US_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? '0 : TW'(SETTLE_CYCLES - 1);
  localparam logic [AW-1:0] MAX_A       = AW'(MAX_ATTEMPTS);

  nav_state_t       r_state;
  nav_fault_t       r_fault;
  logic             r_run_us, r_orient_req, r_calc_req, r_check_req, r_tx;
  logic             r_reached;
  logic [CMD_W-1:0] r_move_cmd;
  logic [LOC_W-1:0] r_orig, r_upd;
  logic [AW-1:0]    r_attempt;

  logic [7:0]       w_dur;
  logic [TW-1:0]    w_prod;
  logic [TW-1:0]    w_move_load;
  logic             w_tmr_load;
  logic [TW-1:0]    w_tmr_val;
  logic             w_tmr_zero;

  assign w_dur       = (r_state == ST_SETTLE1) ? PROBE_CMD[DUR_MSB:DUR_LSB]
                                               : bus.calc_cmd[DUR_MSB:DUR_LSB];
  assign w_prod      = TW'(w_dur) * TW'(UNIT_CYCLES);
  assign w_move_load = (w_prod == '0) ? '0 : w_prod - TW'(1);

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = TO_LOAD;
    case (r_state)
      ST_IDLE:           w_tmr_load = bus.enable;
      ST_US1, ST_US2: begin
        if (bus.ultrasound_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = SETTLE_LOAD;
        end
      end
      ST_SETTLE1: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = w_move_load;
        end
      end
      ST_PROBE, ST_MOVE: w_tmr_load = w_tmr_zero;
      ST_CALC: begin
        if (bus.calc_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = w_move_load;
        end
      end
      ST_CHECK:          w_tmr_load = bus.check_done && !bus.at_target && (r_attempt != MAX_A);
      default:           ;
    endcase
  end

  nav_timer #(.W(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_clr      (bus.abort),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_fault      <= FLT_NONE;
      r_run_us     <= 1'b0;
      r_orient_req <= 1'b0;
      r_calc_req   <= 1'b0;
      r_check_req  <= 1'b0;
      r_tx         <= 1'b0;
      r_reached    <= 1'b0;
      r_move_cmd   <= '0;
      r_orig       <= '0;
      r_upd        <= '0;
      r_attempt    <= '0;
    end else begin
      r_run_us     <= 1'b0;
      r_orient_req <= 1'b0;
      r_calc_req   <= 1'b0;
      r_check_req  <= 1'b0;
      r_tx         <= 1'b0;
      if (bus.abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.enable) begin
              r_reached  <= 1'b0;
              r_fault    <= FLT_NONE;
              r_orig     <= '0;
              r_upd      <= '0;
              r_move_cmd <= '0;
              r_attempt  <= AW'(1);
              r_run_us   <= 1'b1;
              r_state    <= ST_US1;
            end
          end
          ST_US1, ST_US2, ST_US3: begin
            // a done arriving on the timeout cycle still counts
            if (bus.ultrasound_done) begin
              case (r_state)
                ST_US1:  r_state <= ST_SETTLE1;
                ST_US2:  r_state <= ST_SETTLE2;
                default: begin
                  r_check_req <= 1'b1;
                  r_state     <= ST_CHECK;
                end
              endcase
            end else if (w_tmr_zero) begin
              r_fault <= FLT_US_TIMEOUT;
              r_state <= ST_FAULT;
            end
          end
          ST_SETTLE1: begin
            if (w_tmr_zero) begin
              r_orig     <= bus.rover_location;
              r_move_cmd <= PROBE_CMD;
              r_tx       <= 1'b1;
              r_state    <= ST_PROBE;
            end
          end
          ST_PROBE: begin
            if (w_tmr_zero) begin
              r_run_us <= 1'b1;
              r_state  <= ST_US2;
            end
          end
          ST_SETTLE2: begin
            if (w_tmr_zero) begin
              r_upd        <= bus.rover_location;
              r_orient_req <= 1'b1;
              r_state      <= ST_ORIENT;
            end
          end
          ST_ORIENT: begin
            if (bus.orient_done) begin
              r_calc_req <= 1'b1;
              r_state    <= ST_CALC;
            end
          end
          ST_CALC: begin
            if (bus.calc_done) begin
              r_move_cmd <= bus.calc_cmd;
              r_tx       <= 1'b1;
              r_state    <= ST_MOVE;
            end
          end
          ST_MOVE: begin
            if (w_tmr_zero) begin
              r_run_us <= 1'b1;
              r_state  <= ST_US3;
            end
          end
          ST_CHECK: begin
            if (bus.check_done) begin
              if (bus.at_target) begin
                r_reached <= 1'b1;
                r_state   <= ST_IDLE;
              end else if (r_attempt == MAX_A) begin
                r_fault <= FLT_ATTEMPTS;
                r_state <= ST_FAULT;
              end else begin
                r_attempt <= r_attempt + AW'(1);
                r_orig    <= '0;
                r_upd     <= '0;
                r_run_us  <= 1'b1;
                r_state   <= ST_US1;
              end
            end
          end
          ST_FAULT: if (!bus.enable) r_state <= ST_IDLE;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.run_ultrasound    = r_run_us;
  assign bus.orient_req        = r_orient_req;
  assign bus.calc_req          = r_calc_req;
  assign bus.check_req         = r_check_req;
  assign bus.transmit_ir       = r_tx;
  assign bus.move_command      = r_move_cmd;
  assign bus.original_location = r_orig;
  assign bus.updated_location  = r_upd;
  assign bus.reached_target    = r_reached;
  assign bus.fault             = r_fault;
  assign bus.attempt           = r_attempt;
  assign bus.state             = r_state;
endmodule

// File: tb/tb_nav_sequencer.sv
// Directed bench for nav_sequencer with short settle/unit/timeout values.
module tb_nav_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  nav_if #(.LOC_W(12), .CMD_W(12), .AW(2)) bus ();

  nav_sequencer #(
    .LOC_W(12), .CMD_W(12), .SETTLE_CYCLES(4), .UNIT_CYCLES(3),
    .PROBE_CMD(12'h005), .US_TIMEOUT(20), .MAX_ATTEMPTS(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start();
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
  endtask

  task automatic us_done_after(input int n);
    repeat (n - 1) tick();
    bus.ultrasound_done = 1'b1;
    tick();
    bus.ultrasound_done = 1'b0;
  endtask

  task automatic wait_leave(input logic [3:0] st, input int budget, output int cnt);
    cnt = 0;
    while (bus.state === st && cnt < budget) begin
      cnt++;
      tick();
    end
  endtask

  // from US1 cycle 1 to MOVE cycle 1
  task automatic loop_to_move(input logic [11:0] cmd, output bit ok);
    int c;
    ok = 1'b1;
    us_done_after(5);            if (bus.state !== 4'h2) ok = 1'b0;
    wait_leave(4'h2, 50, c);     if (bus.state !== 4'h3) ok = 1'b0;
    wait_leave(4'h3, 100, c);    if (bus.state !== 4'h4) ok = 1'b0;
    us_done_after(3);            if (bus.state !== 4'h5) ok = 1'b0;
    wait_leave(4'h5, 50, c);     if (bus.state !== 4'h6) ok = 1'b0;
    bus.orient_done = 1'b1; tick(); bus.orient_done = 1'b0;
    if (bus.state !== 4'h7) ok = 1'b0;
    bus.calc_cmd = cmd; bus.calc_done = 1'b1; tick(); bus.calc_done = 1'b0;
    if (bus.state !== 4'h8) ok = 1'b0;
  endtask

  task automatic loop_to_check(input logic [11:0] cmd, output bit ok);
    int c;
    loop_to_move(cmd, ok);
    wait_leave(4'h8, 1000, c);   if (bus.state !== 4'h9) ok = 1'b0;
    us_done_after(2);            if (bus.state !== 4'hA) ok = 1'b0;
  endtask

  function automatic logic [58:0] all_outs();
    return {bus.run_ultrasound, bus.orient_req, bus.calc_req, bus.check_req,
            bus.transmit_ir, bus.move_command, bus.original_location,
            bus.updated_location, bus.reached_target, bus.fault, bus.attempt,
            bus.state, 4'h0};
  endfunction

  task automatic test_reset();
    repeat (3) tick();
    n_vec++;
    if (all_outs() !== 59'h0) begin n_err++; $display("FAIL reset_outputs: got %0h want 0", all_outs()); end
    reset = 1'b1;
    tick();
    n_vec++;
    if (bus.state !== 4'h0) begin n_err++; $display("FAIL reset_idle: state %0h want 0", bus.state); end
  endtask

  task automatic test_locate_probe();
    int c;
    start();
    n_vec++;
    if (bus.state !== 4'h1 || bus.run_ultrasound !== 1'b1 || bus.attempt !== 2'd1) begin
      n_err++; $display("FAIL start: state %0h run_us %b attempt %0d want 1/1/1", bus.state, bus.run_ultrasound, bus.attempt);
    end
    bus.rover_location = 12'h312;
    us_done_after(5);
    wait_leave(4'h2, 50, c);
    n_vec++;
    if (c !== 4) begin n_err++; $display("FAIL settle1_len: got %0d want 4", c); end
    n_vec++;
    if (bus.state !== 4'h3 || bus.transmit_ir !== 1'b1 || bus.move_command !== 12'h005 || bus.original_location !== 12'h312) begin
      n_err++; $display("FAIL probe_entry: state %0h tx %b cmd %0h orig %0h want 3/1/005/312",
                        bus.state, bus.transmit_ir, bus.move_command, bus.original_location);
    end
    tick();
    n_vec++;
    if (bus.transmit_ir !== 1'b0) begin n_err++; $display("FAIL tx_pulse: got %b want 0", bus.transmit_ir); end
    wait_leave(4'h3, 100, c);
    n_vec++;
    if (c + 1 !== 15) begin n_err++; $display("FAIL probe_len: got %0d want 15", c + 1); end
    n_vec++;
    if (bus.state !== 4'h4 || bus.run_ultrasound !== 1'b1) begin
      n_err++; $display("FAIL us2_entry: state %0h run_us %b want 4/1", bus.state, bus.run_ultrasound);
    end
    bus.rover_location = 12'h318;
    us_done_after(3);
    wait_leave(4'h5, 50, c);
    n_vec++;
    if (bus.state !== 4'h6 || bus.orient_req !== 1'b1 || bus.updated_location !== 12'h318 || bus.original_location !== 12'h312) begin
      n_err++; $display("FAIL orient_entry: state %0h oreq %b upd %0h orig %0h want 6/1/318/312",
                        bus.state, bus.orient_req, bus.updated_location, bus.original_location);
    end
  endtask

  task automatic test_arrival();
    int c;
    bus.orient_done = 1'b1; tick(); bus.orient_done = 1'b0;
    n_vec++;
    if (bus.state !== 4'h7 || bus.calc_req !== 1'b1) begin n_err++; $display("FAIL calc_entry: state %0h creq %b want 7/1", bus.state, bus.calc_req); end
    bus.calc_cmd = 12'h203; bus.calc_done = 1'b1; tick(); bus.calc_done = 1'b0;
    n_vec++;
    if (bus.transmit_ir !== 1'b1 || bus.move_command !== 12'h203) begin
      n_err++; $display("FAIL move_entry: tx %b cmd %0h want 1/203", bus.transmit_ir, bus.move_command);
    end
    wait_leave(4'h8, 100, c);
    n_vec++;
    if (c !== 9) begin n_err++; $display("FAIL move_len: got %0d want 9", c); end
    us_done_after(2);
    n_vec++;
    if (bus.state !== 4'hA || bus.check_req !== 1'b1) begin n_err++; $display("FAIL check_entry: state %0h chk %b want A/1", bus.state, bus.check_req); end
    bus.at_target = 1'b1; bus.check_done = 1'b1; tick(); bus.check_done = 1'b0; bus.at_target = 1'b0;
    tick();
    n_vec++;
    if (bus.state !== 4'h0 || bus.reached_target !== 1'b1 || bus.attempt !== 2'd1 || bus.fault !== 2'd0) begin
      n_err++; $display("FAIL arrived: state %0h reached %b attempt %0d fault %0d want 0/1/1/0",
                        bus.state, bus.reached_target, bus.attempt, bus.fault);
    end
  endtask

  task automatic test_attempts_exhausted();
    bit ok;
    start();
    loop_to_check(12'h001, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL attempt1_path: flow ok %b want 1", ok); end
    bus.check_done = 1'b1; tick(); bus.check_done = 1'b0;
    n_vec++;
    if (bus.state !== 4'h1 || bus.attempt !== 2'd2 || bus.run_ultrasound !== 1'b1 || bus.original_location !== 12'h0 || bus.reached_target !== 1'b0) begin
      n_err++; $display("FAIL retry: state %0h attempt %0d run_us %b orig %0h reached %b want 1/2/1/0/0",
                        bus.state, bus.attempt, bus.run_ultrasound, bus.original_location, bus.reached_target);
    end
    loop_to_check(12'h002, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL attempt2_path: flow ok %b want 1", ok); end
    bus.enable = 1'b1;
    bus.check_done = 1'b1; tick(); bus.check_done = 1'b0;
    tick();
    n_vec++;
    if (bus.state !== 4'hF || bus.fault !== 2'd2) begin n_err++; $display("FAIL exhausted: state %0h fault %0d want F/2", bus.state, bus.fault); end
    bus.enable = 1'b0;
    tick();
    n_vec++;
    if (bus.state !== 4'h0 || bus.fault !== 2'd2) begin n_err++; $display("FAIL fault_release: state %0h fault %0d want 0/2", bus.state, bus.fault); end
  endtask

  task automatic test_us_timeout();
    int c;
    start();
    n_vec++;
    if (bus.fault !== 2'd0) begin n_err++; $display("FAIL fault_cleared: got %0d want 0", bus.fault); end
    us_done_after(5);
    wait_leave(4'h2, 50, c);
    wait_leave(4'h3, 100, c);
    wait_leave(4'h4, 100, c);
    n_vec++;
    if (c !== 20 || bus.state !== 4'hF || bus.fault !== 2'd1) begin
      n_err++; $display("FAIL us_timeout: cycles %0d state %0h fault %0d want 20/F/1", c, bus.state, bus.fault);
    end
    tick();
    n_vec++;
    if (bus.state !== 4'h0 || bus.fault !== 2'd1) begin n_err++; $display("FAIL timeout_idle: state %0h fault %0d want 0/1", bus.state, bus.fault); end
  endtask

  task automatic test_zero_move();
    int c;
    bit ok;
    start();
    loop_to_move(12'h100, ok);
    wait_leave(4'h8, 100, c);
    n_vec++;
    if (!ok || c !== 1 || bus.state !== 4'h9 || bus.run_ultrasound !== 1'b1 || bus.move_command !== 12'h100) begin
      n_err++; $display("FAIL zero_move: ok %b cycles %0d state %0h run_us %b cmd %0h want 1/1/9/1/100",
                        ok, c, bus.state, bus.run_ultrasound, bus.move_command);
    end
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
  endtask

  task automatic test_abort();
    bit ok;
    logic [4:0] seen;
    logic       moved;
    start();
    loop_to_move(12'h00A, ok);
    repeat (3) tick();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    n_vec++;
    if (!ok || bus.state !== 4'h0 || bus.move_command !== 12'h00A || bus.attempt !== 2'd1 || bus.fault !== 2'd0) begin
      n_err++; $display("FAIL abort_idle: ok %b state %0h cmd %0h attempt %0d fault %0d want 1/0/00A/1/0",
                        ok, bus.state, bus.move_command, bus.attempt, bus.fault);
    end
    seen = '0; moved = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= {bus.run_ultrasound, bus.orient_req, bus.calc_req, bus.check_req, bus.transmit_ir};
      if (bus.state !== 4'h0) moved = 1'b1;
      tick();
    end
    n_vec++;
    if (seen !== 5'b0 || moved !== 1'b0) begin n_err++; $display("FAIL abort_quiet: pulses %b left_idle %b want 0/0", seen, moved); end
  endtask

  task automatic test_reset_mid_settle();
    start();
    us_done_after(5);
    tick();
    n_vec++;
    if (bus.state !== 4'h2 || bus.attempt !== 2'd1) begin n_err++; $display("FAIL pre_reset: state %0h attempt %0d want 2/1", bus.state, bus.attempt); end
    reset = 1'b0;
    tick();
    n_vec++;
    if (all_outs() !== 59'h0) begin n_err++; $display("FAIL mid_reset: got %0h want 0", all_outs()); end
    reset = 1'b1;
    repeat (8) tick();
    n_vec++;
    if (bus.state !== 4'h0 || bus.original_location !== 12'h0) begin
      n_err++; $display("FAIL post_reset: state %0h orig %0h want 0/0", bus.state, bus.original_location);
    end
  endtask

  initial begin
    bus.enable = 1'b0; bus.abort = 1'b0; bus.rover_location = '0;
    bus.ultrasound_done = 1'b0; bus.orient_done = 1'b0; bus.calc_done = 1'b0;
    bus.calc_cmd = '0; bus.check_done = 1'b0; bus.at_target = 1'b0;
    test_reset();
    test_locate_probe();
    test_arrival();
    test_attempts_exhausted();
    test_us_timeout();
    test_zero_move();
    test_abort();
    test_reset_mid_settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
